log_accum_sequencer: RTL and testbench
======================================

// Module: log_accum_sequencer
// PURPOSE
//  Streams LEN signed log-domain operands through one shared logAddition_bitshift instance.
//  Folds them into a running log-domain sum: acc = acc (+) x[i], one operand per clock.
//  Sits between an operand source (valid/ready) and a result sink (valid/ready).
//  Owns the accumulator registers, operand counter and FSM; the adder itself stays combinational.
// PARAMETERS
//  BITS   18  log magnitude width, fixed point 9.9 (matches the adder build)
//  LEN_W  8   width of the operand-count input
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle request to begin a sum; sampled only in IDLE
//  len        in   LEN_W  operand count, captured on accepted start; 0 is illegal
//  in_valid   in   1      operand valid
//  in_ready   out  1      operand accept; transfer when in_valid & in_ready
//  in_x       in   BITS   operand log magnitude
//  in_s       in   1      operand sign (1 = negative)
//  out_valid  out  1      result valid
//  out_ready  in   1      result accept
//  out_z      out  BITS   result log magnitude (= acc)
//  out_sz     out  1      result sign (= acc_s)
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; acc, acc_s, remaining all 0.
//   Outputs under reset: in_ready=0, out_valid=0, out_z=0, out_sz=0, busy=0.
//  FSM states: IDLE, LOAD, ACCUM, DONE. All outputs are registered or decoded from state only.
//  IDLE:
//   start=1 & len!=0 -> LOAD, remaining<=len.
//   start=1 & len==0 -> ignored, stay IDLE.
//  LOAD (in_ready=1), on input transfer:
//   acc<=in_x, acc_s<=in_s, remaining<=remaining-1.
//   No addition is done here: log zero is not representable, so the first operand seeds acc.
//   len==1 -> DONE; otherwise -> ACCUM.
//  ACCUM (in_ready=1), on input transfer:
//   acc<=Z, acc_s<=Sz, from the adder with X=acc, Sx=acc_s, Y=in_x, Sy=in_s.
//   remaining<=remaining-1.
//   Transfer with remaining==1 -> DONE.
//  in_valid=0 cycles: no state or counter change (bubbles allowed anywhere).
//  DONE (in_ready=0, out_valid=1):
//   out_z/out_sz hold acc/acc_s, stable while out_ready=0.
//   out_ready=1 -> IDLE next cycle; out_valid low that cycle.
//  start outside IDLE is ignored; len changes after capture have no effect.
//  Throughput: 1 operand/clk. Latency: last operand transfer -> out_valid = 1 clk.
//   Total time from start = len + 1 clocks minimum, plus 1 clk of result handshake.
//  Arithmetic: adder output truncated to BITS; no saturation.
//   Equal magnitudes with opposite signs take the adder's own tie path; no special case.
//  Reset mid-operation: aborts immediately to IDLE; the partial sum is discarded.
// TESTING
//  T1 len=2: (18'd1024,+), (18'd512,+) back-to-back -> out_z=18'd1280, out_sz=0,
//     out_valid on the clk after the 2nd transfer.
//  T2 len=2: (18'd1024,-), (18'd512,+) -> out_z=18'd256, out_sz=1 (deltaM path, sign of larger).
//  T3 len=1: (18'd777,-) -> out_z=18'd777, out_sz=1; the adder result is unused.
//  T4 len=3 with in_valid gaps of 2 clks plus out_ready held low 5 clks
//     -> same result as gap-free; out_z stable and out_valid high throughout the stall.
//  T5 start with len=0 -> busy stays 0, in_ready stays 0.
//     start pulsed while in ACCUM -> ignored, count unaffected.
//  T6 rst_n low mid-ACCUM (after 1 of 4 operands) -> all outputs 0 asynchronously.
//     A fresh len=1 run afterwards returns its operand unchanged.

Source files
------------

// File: rtl/log_accum_sequencer.sv
// ---------------------------------------------------------------------------
// log_accum_sequencer
//
// Folds a stream of LEN signed log-domain operands into one running log-domain
// sum, acc = acc (+) x[i], at one operand per clock. A single combinational
// bit-shift log adder is shared across the whole run. This module holds the
// accumulator, the operand counter and the control FSM.
//
// Magnitudes are signed 9.9 fixed point (log2 of the linear value).
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a sum (sampled only when idle)
//   len        in   LEN_W  operand count, captured with start; 0 is ignored
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand accept (transfer on in_valid & in_ready)
//   in_x       in   BITS   operand log magnitude
//   in_s       in   1      operand sign, 1 = negative
//   out_valid  out  1      result valid
//   out_ready  in   1      result accept
//   out_z      out  BITS   result log magnitude
//   out_sz     out  1      result sign
//   busy       out  1      high whenever a sum is in progress or pending
// ---------------------------------------------------------------------------
module log_accum_sequencer #(
    parameter int BITS  = 18,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_x,
    input  logic             in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_z,
    output logic             out_sz,
    output logic             busy
);

    localparam int FRAC = 9;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // 1.0 in the 9.9 log format
    localparam logic signed [BITS-1:0] ONE = BITS'(1 << FRAC);

    logic [1:0]             state;
    logic [LEN_W-1:0]       remaining;
    logic signed [BITS-1:0] acc;
    logic                   acc_s;

    // Result of the bit-shift correction, wrapped to BITS (no saturation).
    // Same signs:     z = max + 2^-d
    // Opposite signs: z = max - 3 * 2^-d
    function automatic logic signed [BITS-1:0] wrap_sum(
        input logic signed [BITS-1:0] mx,
        input logic signed [BITS-1:0] t,
        input logic                   same_sign
    );
        logic signed [BITS-1:0] t3;
        t3 = t + (t <<< 1);
        if (same_sign)
            return mx + t;
        else
            return mx - t3;
    endfunction

    // ---------------- combinational log adder ----------------
    logic signed [BITS-1:0] in_xs;
    logic                   x_ge_y;
    logic signed [BITS-1:0] mx;
    logic signed [BITS-1:0] mn;
    logic [BITS:0]          d;
    logic [BITS:0]          d_int;
    logic signed [BITS-1:0] t;
    logic signed [BITS-1:0] add_z;
    logic                   add_s;

    always_comb begin
        in_xs  = in_x;
        x_ge_y = (acc >= in_xs);
        mx     = x_ge_y ? acc : in_xs;
        mn     = x_ge_y ? in_xs : acc;
        // Distance between operands, one bit wider so it cannot overflow
        d      = {mx[BITS-1], mx} - {mn[BITS-1], mn};
        d_int  = d >> FRAC;
        // Shift amounts past the fraction width flush the correction to 0
        t      = ONE >> d_int;
        add_z  = wrap_sum(mx, t, acc_s == in_s);
        // Sign of the larger magnitude; ties keep the accumulator's sign
        add_s  = x_ge_y ? acc_s : in_s;
    end

    // ---------------- control and accumulator ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            acc       <= '0;
            acc_s     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (len != '0)) begin
                        remaining <= len;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The first operand seeds acc: log zero has no encoding
                    if (in_valid) begin
                        acc       <= in_xs;
                        acc_s     <= in_s;
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == LEN_W'(1)) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc       <= add_z;
                        acc_s     <= add_s;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1))
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_LOAD) || (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_z     = acc;
    assign out_sz    = acc_s;

endmodule

// File: tb/tb_log_accum_sequencer.sv
module tb_log_accum_sequencer;

    localparam int BITS  = 18;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  in_x;
    logic             in_s;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_z;
    logic             out_sz;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [BITS-1:0] z;
        logic            s;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    log_accum_sequencer #(.BITS(BITS), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_sz    (out_sz),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Present one operand and hold it until it is accepted (bounded).
    task automatic send(input logic [BITS-1:0] x, input logic s);
        int n;
        in_valid = 1'b1;
        in_x     = x;
        in_s     = s;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_accept: in_ready=%0b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit seen);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        seen = out_valid;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, out_z, out_sz, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b z=%0d sz=%0b busy=%0b required all 0",
                     in_ready, out_valid, out_z, out_sz, busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        exp_t e;
        do_start(8'd2);
        sb.push_back('{z: 18'd1280, s: 1'b0});
        send(18'd1024, 1'b0);
        send(18'd512, 1'b0);
        // One clock after the last transfer the result must already be valid
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_latency: out_valid=%0b required=1", out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t1_result: z=%0d sz=%0b required z=%0d sz=%0b", out_z, out_sz, e.z, e.s);
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_release: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_opposite_sign();
        exp_t e;
        bit   seen;
        do_start(8'd2);
        sb.push_back('{z: 18'd256, s: 1'b1});
        send(18'd1024, 1'b1);
        send(18'd512, 1'b0);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t2_result: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        release_result();
    endtask

    task automatic test_single();
        exp_t e;
        bit   seen;
        do_start(8'd1);
        sb.push_back('{z: 18'd777, s: 1'b1});
        send(18'd777, 1'b1);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t3_result: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        release_result();
    endtask

    // A negative log magnitude (value below 1.0) must compare as signed.
    task automatic test_negative_mag();
        exp_t e;
        bit   seen;
        do_start(8'd2);
        sb.push_back('{z: 18'd640, s: 1'b0});
        send(18'h3FE00, 1'b0);
        send(18'd512, 1'b0);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL neg_mag_result: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        release_result();
    endtask

    task automatic test_bubbles_stall();
        exp_t e;
        bit   seen;
        int   bad;
        do_start(8'd3);
        sb.push_back('{z: 18'd1792, s: 1'b0});
        send(18'd1024, 1'b0);
        tick(); tick();
        send(18'd512, 1'b0);
        tick(); tick();
        send(18'd1280, 1'b0);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t4_result: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_z !== e.z || out_sz !== e.s)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t4_stall_hold: unstable_cycles=%0d required 0 (z=%0d required %0d)",
                     bad, out_z, e.z);
        end
        release_result();
    endtask

    task automatic test_ignored_start();
        exp_t e;
        bit   seen;
        int   bad;
        start = 1'b1;
        len   = 8'd0;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b0 || in_ready !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL t5_len0: active_cycles=%0d required 0", bad);
        end
        do_start(8'd3);
        sb.push_back('{z: 18'd1536, s: 1'b0});
        send(18'd1024, 1'b0);
        // start with a different length while accumulating must be ignored
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        send(18'd512, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t5_count_kept: out_valid=%0b busy=%0b required 0 1", out_valid, busy);
        end
        send(18'd512, 1'b0);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t5_result: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        release_result();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bit   seen;
        do_start(8'd4);
        send(18'd1024, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_z, out_sz, busy} !== '0) begin
            failures++;
            $display("FAIL t6_async_reset: rdy=%0b vld=%0b z=%0d sz=%0b busy=%0b required all 0",
                     in_ready, out_valid, out_z, out_sz, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(8'd1);
        sb.push_back('{z: 18'd42, s: 1'b0});
        send(18'd42, 1'b0);
        wait_out(seen);
        e = sb.pop_front();
        checks++;
        if (!seen || out_z !== e.z || out_sz !== e.s) begin
            failures++;
            $display("FAIL t6_fresh_run: vld=%0b z=%0d sz=%0b required z=%0d sz=%0b",
                     out_valid, out_z, out_sz, e.z, e.s);
        end
        release_result();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_s      = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_opposite_sign();
        test_single();
        test_negative_mag();
        test_bubbles_stall();
        test_ignored_start();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
